// File: rtl/alu_pkg.sv
// Shared ALU function codes and widths for the RV32I core.
// Codes are {funct7[5], funct3}, so the decoder can select a function by name.
package alu_pkg;

    localparam int FN_W = 4;

    localparam logic [FN_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [FN_W-1:0] ALU_SLL  = 4'h1;
    localparam logic [FN_W-1:0] ALU_SLT  = 4'h2;
    localparam logic [FN_W-1:0] ALU_SLTU = 4'h3;
    localparam logic [FN_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [FN_W-1:0] ALU_SRL  = 4'h5;
    localparam logic [FN_W-1:0] ALU_OR   = 4'h6;
    localparam logic [FN_W-1:0] ALU_AND  = 4'h7;
    localparam logic [FN_W-1:0] ALU_SUB  = 4'h8;
    localparam logic [FN_W-1:0] ALU_SRA  = 4'hD;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift stages by bit-reversing the data on the way in and out.
module alu_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,     // 1 = right, 0 = left
    input  logic             arith,   // replicate sign bit on right shifts
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_stage [0:SHW];
    logic             w_fill;

    assign w_fill = arith & dir & data[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev_in
            assign w_stage[0][gi] = dir ? data[gi] : data[WIDTH-1-gi];
        end

        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign w_stage[gi+1] = shamt[gi] ? {{SH{w_fill}}, w_stage[gi][WIDTH-1:SH]}
                                             : w_stage[gi];
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_rev_out
            assign result[gi] = dir ? w_stage[SHW][gi] : w_stage[SHW][WIDTH-1-gi];
        end
    endgenerate

endmodule

// File: rtl/alu_core.sv
// Registered RV32I integer ALU: one result per clock, 1-cycle latency.
// Compares share the subtractor; zero is derived from the same next-state value as out.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [FN_W-1:0]  fn,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    logic             w_use_sub;
    logic [WIDTH-1:0] w_y_op;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    // Everything except ADD needs x - y (SUB, SLT, SLTU); x + ~y + 1.
    assign w_use_sub = (fn != ALU_ADD);
    assign w_y_op    = w_use_sub ? ~y : y;
    assign {w_carry, w_sum} = {1'b0, x} + {1'b0, w_y_op} + (WIDTH+1)'(w_use_sub);

    // Signed: when signs differ, x is less iff x is negative; otherwise the difference sign decides.
    assign w_slt  = (x[WIDTH-1] != y[WIDTH-1]) ? x[WIDTH-1] : w_sum[WIDTH-1];
    assign w_sltu = ~w_carry;

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data   (x),
        .shamt  (y[SHW-1:0]),
        .dir    (fn[2]),
        .arith  (fn[3]),
        .result (w_shift)
    );

    always_comb begin
        w_result = '0;
        case (fn)
            ALU_ADD,
            ALU_SUB:  w_result = w_sum;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_result = w_shift;
            ALU_SLT:  w_result = WIDTH'(w_slt);
            ALU_SLTU: w_result = WIDTH'(w_sltu);
            ALU_XOR:  w_result = x ^ y;
            ALU_OR:   w_result = x | y;
            ALU_AND:  w_result = x & y;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_zero <= 1'b1;
        end else begin
            r_out  <= w_result;
            r_zero <= (w_result == '0);
        end
    end

    assign out  = r_out;
    assign zero = r_zero;

endmodule

// File: tb/tb_alu_core.sv
// Directed and random checks for alu_core using an expected-result queue.
// Each transaction is driven on the falling edge and checked 1 ns after the next rising edge.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  fn;
    logic [31:0] out;
    logic        zero;

    typedef struct packed {
        logic [31:0] out;
        logic        zero;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_core #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .fn    (fn),
        .out   (out),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        logic signed [31:0] sa;
        logic [4:0]         sh;
        sa = a;
        sh = b[4:0];
        case (f)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h1: return a << sh;
            4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'h4: return a ^ b;
            4'h5: return a >> sh;
            4'hD: return 32'(sa >>> sh);
            4'h6: return a | b;
            4'h7: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_out(input string tag, input logic [31:0] e_out, input logic e_zero);
        n_checks++;
        assert (out === e_out) else begin
            n_fail++;
            $error("FAIL %s out: got %08h expected %08h", tag, out, e_out);
        end
        n_checks++;
        assert (zero === e_zero) else begin
            n_fail++;
            $error("FAIL %s zero: got %0b expected %0b", tag, zero, e_zero);
        end
    endtask

    // One transaction: drive, push expectation, wait for capture edge, pop and compare.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f);
        exp_t e;
        logic [31:0] r;
        @(negedge clk);
        x  = a;
        y  = b;
        fn = f;
        r  = ref_alu(a, b, f);
        e.out  = r;
        e.zero = (r == 32'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard: got empty queue expected entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_out(tag, e.out, e.zero);
        end
        $display("txn %-10s x=%08h y=%08h fn=%h -> out=%08h zero=%0b", tag, a, b, f, out, zero);
    endtask

    initial begin
        rst_n = 1'b1;
        x = '0; y = '0; fn = '0;
        #1 rst_n = 1'b0;
        #1;
        check_out("reset", 32'h0, 1'b1);

        @(negedge clk);
        x = 32'h1234_5678; y = 32'h1; fn = 4'h0;
        @(posedge clk); #1;
        check_out("rst_hold", 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        step("add_wrap",  32'hFFFF_FFFF, 32'h1, 4'h0);
        step("sub_wrap",  32'h0, 32'h1, 4'h8);
        step("slt_neg",   32'hFFFF_FFFF, 32'h1, 4'h2);
        step("sltu_big",  32'hFFFF_FFFF, 32'h1, 4'h3);
        step("sltu_less", 32'h1, 32'hFFFF_FFFF, 4'h3);
        step("slt_pos",   32'h7FFF_FFFF, 32'h8000_0000, 4'h2);
        step("beq_sub",   32'h5, 32'h5, 4'h8);
        step("sll",       32'h8000_0001, 32'h24, 4'h1);
        step("srl",       32'h8000_0001, 32'h24, 4'h5);
        step("sra",       32'h8000_0001, 32'h24, 4'hD);
        step("sra_31",    32'h8000_0000, 32'hFFFF_FFFF, 4'hD);
        step("xor",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h4);
        step("or",        32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h6);
        step("and",       32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h7);
        step("undef_c",   32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'hC);
        step("undef_9",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h9);

        // Inputs moving between edges must not disturb the held result.
        step("pre_hold",  32'h0000_0003, 32'h0000_0004, 4'h0);
        #2;
        x = 32'hDEAD_BEEF; fn = 4'h4;
        #1;
        check_out("mid_hold", 32'h7, 1'b0);

        // Asynchronous reset mid-cycle with a nonzero result held.
        step("pre_rst",   32'h0, 32'h1, 4'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [3:0]  rf;
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            rf = 4'($urandom_range(0, 15));
            step("rand", ra, rb, rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
